// File: rtl/tri_batch_scanner_if.sv
// Request/result channels between the batch scanner and the triangle reader /
// intersection datapath. The scanner side is the master.
interface tri_batch_scanner_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned IDX_W = 32,
  parameter int unsigned T_W   = 32
);
  logic                 req_valid;
  logic [IDX_W-1:0]     req_index;
  logic                 req_ready;
  logic                 res_valid;
  logic [LANES-1:0]     res_hit;
  logic [LANES*T_W-1:0] res_t;

  modport master (
    output req_valid, req_index,
    input  req_ready, res_valid, res_hit, res_t
  );

  modport slave (
    input  req_valid, req_index,
    output req_ready, res_valid, res_hit, res_t
  );
endinterface

// File: rtl/tri_batch_scanner.sv
// Batch controller: issues triangle-group requests with an in-flight limit and
// reduces in-order lane results to the closest (or first, in any-hit mode) hit.
module tri_batch_scanner #(
  parameter int unsigned LANES        = 2,
  parameter int unsigned IDX_W        = 32,
  parameter int unsigned T_W          = 32,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int          MIN_T        = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic [IDX_W-1:0]           i_tri_cnt,
  input  logic                       i_any_hit,
  input  logic [T_W-1:0]             i_t_max,
  output logic                       o_busy,
  tri_batch_scanner_if.master        io_bus,
  output logic                       o_finish,
  output logic                       o_hit,
  output logic [T_W-1:0]             o_t,
  output logic [IDX_W-1:0]           o_tri_index
);
  localparam int unsigned OUT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic signed [T_W-1:0] T_SAT = {1'b0, {(T_W-1){1'b1}}};
  localparam logic signed [T_W-1:0] T_LO  = T_W'(MIN_T);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_cnt;
  logic                   r_any;
  logic signed [T_W-1:0]  r_t_max;
  logic [IDX_W-1:0]       r_groups;
  logic [IDX_W-1:0]       r_issued;
  logic [OUT_W-1:0]       r_out;
  logic                   r_req_valid;
  logic [IDX_W-1:0]       r_req_index;
  logic [IDX_W-1:0]       r_ret_base;
  logic                   r_busy;
  logic                   r_finish;
  logic                   r_hit;
  logic signed [T_W-1:0]  r_t;
  logic [IDX_W-1:0]       r_tri_index;

  state_t                 w_state_nxt;
  logic                   w_req_hs;
  logic                   w_res_take;
  logic [IDX_W-1:0]       w_issued_nxt;
  logic [OUT_W-1:0]       w_out_nxt;
  logic                   w_req_valid_nxt;
  logic [IDX_W-1:0]       w_groups;
  logic [LANES-1:0]       w_lane_acc;
  logic                   w_cand_vld;
  logic signed [T_W-1:0]  w_cand_t;
  logic [IDX_W-1:0]       w_cand_idx;
  logic                   w_update;
  logic                   w_any_stop;

  assign io_bus.req_valid = r_req_valid;
  assign io_bus.req_index = r_req_index;
  assign o_busy           = r_busy;
  assign o_finish         = r_finish;
  assign o_hit            = r_hit;
  assign o_t              = r_t;
  assign o_tri_index      = r_tri_index;

  // ceil(cnt/LANES) built from quotient + remainder so it cannot overflow
  assign w_groups = IDX_W'(i_tri_cnt / IDX_W'(LANES))
                  + IDX_W'((i_tri_cnt % IDX_W'(LANES)) != '0);

  assign w_req_hs     = r_req_valid && io_bus.req_ready;
  assign w_res_take   = io_bus.res_valid && (r_out != '0);
  assign w_issued_nxt = r_issued + IDX_W'(w_req_hs);
  assign w_out_nxt    = r_out + OUT_W'(w_req_hs) - OUT_W'(w_res_take);

  // Per-lane acceptance: in range of the batch, raw hit, MIN_T <= t < t_max
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IDX_W:0]        w_idx;
    logic signed [T_W-1:0] w_t;
    assign w_idx = {1'b0, r_ret_base} + (IDX_W+1)'(k);
    assign w_t   = $signed(io_bus.res_t[k*T_W +: T_W]);
    assign w_lane_acc[k] = (w_idx < {1'b0, r_cnt}) && io_bus.res_hit[k]
                         && (w_t >= T_LO) && (w_t < r_t_max);
  end

  // Minimum accepted t in the beat; strict compare keeps the lower lane on ties
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_t   = T_SAT;
    w_cand_idx = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (w_lane_acc[k] &&
          (!w_cand_vld || ($signed(io_bus.res_t[k*T_W +: T_W]) < w_cand_t))) begin
        w_cand_vld = 1'b1;
        w_cand_t   = $signed(io_bus.res_t[k*T_W +: T_W]);
        w_cand_idx = r_ret_base + IDX_W'(k);
      end
    end
  end

  assign w_update   = w_res_take && w_cand_vld && !(r_any && r_hit) && (w_cand_t < r_t);
  assign w_any_stop = r_any && w_res_take && w_cand_vld && !r_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // An any-hit stop with nothing left in flight skips DRAIN to keep finish latency fixed
  always_comb begin
    w_state_nxt     = r_state;
    w_req_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = (i_tri_cnt == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_any_stop)                                  w_state_nxt = (w_out_nxt == '0) ? S_DONE : S_DRAIN;
        else if (w_req_hs && (w_issued_nxt == r_groups)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_out_nxt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_state_nxt == S_ISSUE)
      w_req_valid_nxt = (r_state == S_IDLE) || (w_out_nxt < OUT_W'(MAX_INFLIGHT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_any       <= 1'b0;
      r_t_max     <= '0;
      r_groups    <= '0;
      r_issued    <= '0;
      r_out       <= '0;
      r_req_valid <= 1'b0;
      r_req_index <= '0;
      r_ret_base  <= '0;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
      r_hit       <= 1'b0;
      r_t         <= T_SAT;
      r_tri_index <= '0;
    end else begin
      r_out       <= w_out_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_finish    <= (r_state == S_DONE);
      if ((r_state == S_IDLE) && i_start) begin
        r_cnt       <= i_tri_cnt;
        r_any       <= i_any_hit;
        r_t_max     <= $signed(i_t_max);
        r_groups    <= w_groups;
        r_issued    <= '0;
        r_req_index <= '0;
        r_ret_base  <= '0;
        r_hit       <= 1'b0;
        r_t         <= T_SAT;
        r_tri_index <= '0;
      end else begin
        if (w_req_hs) begin
          r_issued    <= w_issued_nxt;
          r_req_index <= r_req_index + IDX_W'(LANES);
        end
        if (w_res_take) r_ret_base <= r_ret_base + IDX_W'(LANES);
        if (w_update) begin
          r_hit       <= 1'b1;
          r_t         <= w_cand_t;
          r_tri_index <= w_cand_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_tri_batch_scanner.sv
// Randomized bench for tri_batch_scanner: a reader model returns in-order beats
// from a per-batch triangle table; results are compared with a reference model.
module tb_tri_batch_scanner;
  localparam int unsigned LANES        = 2;
  localparam int unsigned IDX_W        = 32;
  localparam int unsigned T_W          = 32;
  localparam int unsigned MAX_INFLIGHT = 8;
  localparam int          MIN_T        = 0;
  localparam logic [31:0] T_SAT        = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [31:0] i_tri_cnt;
  logic        i_any_hit;
  logic [31:0] i_t_max;
  logic        o_busy, o_finish, o_hit;
  logic [31:0] o_t, o_tri_index;

  tri_batch_scanner_if #(.LANES(LANES), .IDX_W(IDX_W), .T_W(T_W)) bus ();

  tri_batch_scanner #(
    .LANES(LANES), .IDX_W(IDX_W), .T_W(T_W), .MAX_INFLIGHT(MAX_INFLIGHT), .MIN_T(MIN_T)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_tri_cnt(i_tri_cnt),
    .i_any_hit(i_any_hit), .i_t_max(i_t_max), .o_busy(o_busy), .io_bus(bus),
    .o_finish(o_finish), .o_hit(o_hit), .o_t(o_t), .o_tri_index(o_tri_index)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          th [64];
  logic [31:0] tt [64];
  int          pend_idx [$];
  int          pend_due [$];
  int          lat = 4;
  bit          res_stall = 0;
  bit          rdy_rand  = 0;
  int          req_cnt, ret_cnt, fin_cnt, fin_cyc, last_res_cyc, exp_next_idx, win_idx;
  bit          hit_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reader + datapath model: accepts requests, returns one beat per request in order
  always @(negedge clk) begin
    int ob;
    int b;
    if (reset) begin
      pend_idx.delete();
      pend_due.delete();
      bus.res_valid = 1'b0;
      bus.req_ready = 1'b0;
    end else begin
      if (o_finish) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      ob = req_cnt - ret_cnt;
      bus.req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.req_valid && bus.req_ready) begin
        check_eq("req_index", 64'(bus.req_index), 64'(exp_next_idx));
        check_eq("inflight_limit", 64'(ob < int'(MAX_INFLIGHT)), 64'd1);
        check_eq("req_after_anyhit", 64'(hit_seen), 64'd0);
        pend_idx.push_back(int'(bus.req_index));
        pend_due.push_back(cyc + lat);
        req_cnt++;
        exp_next_idx += LANES;
      end
      if (!res_stall && pend_idx.size() > 0 && pend_due[0] <= cyc) begin
        b = pend_idx.pop_front();
        void'(pend_due.pop_front());
        bus.res_valid = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          bus.res_hit[k]             = th[(b + k) % 64];
          bus.res_t[k*T_W +: T_W]    = tt[(b + k) % 64];
        end
        ret_cnt++;
        last_res_cyc = cyc;
        if (b == win_idx) hit_seen = 1'b1;
      end else if (pend_idx.size() == 0 && $urandom_range(0, 3) == 0) begin
        // stray beat with nothing in flight; must be ignored
        bus.res_valid = 1'b1;
        bus.res_hit   = '1;
        bus.res_t     = '0;
      end else begin
        bus.res_valid = 1'b0;
        bus.res_hit   = LANES'($urandom);
        bus.res_t     = {$urandom, $urandom};
      end
    end
  end

  // Lanes past cnt always carry a tiny-t hit so any masking slip shows up
  task automatic fill(input int cnt, input int dens);
    for (int i = 0; i < 64; i++) begin
      if (i < cnt) begin
        th[i] = ($urandom_range(0, 99) < dens);
        tt[i] = 32'($urandom_range(0, 32'h0006_0000)) - 32'h0001_0000;
      end else begin
        th[i] = 1'b1;
        tt[i] = 32'h0000_0001;
      end
    end
  endtask

  function automatic bit accepted(input int i, input int cnt, input logic [31:0] tmax);
    return (i < cnt) && th[i] && ($signed(tt[i]) >= MIN_T) && ($signed(tt[i]) < $signed(tmax));
  endfunction

  task automatic run_batch(input string tag, input int cnt, input bit any,
                           input logic [31:0] tmax, input int stall_cyc);
    bit          e_hit;
    logic [31:0] e_t;
    int          e_idx, groups, wg, start_cyc, to;
    bit          gv;
    logic [31:0] gt;
    int          gi;
    groups = (cnt + LANES - 1) / LANES;
    e_hit = 1'b0; e_t = T_SAT; e_idx = 0; wg = -1;
    if (!any) begin
      for (int i = 0; i < cnt; i++)
        if (accepted(i, cnt, tmax) && ($signed(tt[i]) < $signed(e_t))) begin
          e_hit = 1'b1; e_t = tt[i]; e_idx = i;
        end
    end else begin
      for (int g = 0; g < groups && !e_hit; g++) begin
        gv = 1'b0; gt = T_SAT; gi = 0;
        for (int k = 0; k < LANES; k++)
          if (accepted(g*LANES + k, cnt, tmax) && (!gv || $signed(tt[g*LANES+k]) < $signed(gt))) begin
            gv = 1'b1; gt = tt[g*LANES+k]; gi = g*LANES + k;
          end
        if (gv) begin
          e_hit = 1'b1; e_t = gt; e_idx = gi; wg = g;
        end
      end
    end
    req_cnt = 0; ret_cnt = 0; fin_cnt = 0; exp_next_idx = 0; hit_seen = 1'b0;
    win_idx = (wg >= 0) ? wg * LANES : -1;
    res_stall = (stall_cyc > 0);
    @(negedge clk);
    i_start = 1'b1; i_tri_cnt = 32'(cnt); i_any_hit = any; i_t_max = tmax; start_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0; i_tri_cnt = $urandom; i_any_hit = 1'($urandom); i_t_max = $urandom;
    check_eq({tag, ":busy"}, 64'(o_busy), 64'd1);
    if (stall_cyc > 0) begin
      repeat (stall_cyc) @(negedge clk);
      check_eq({tag, ":stall_reqs"}, 64'(req_cnt), 64'(MAX_INFLIGHT));
      check_eq({tag, ":stall_valid"}, 64'(bus.req_valid), 64'd0);
      res_stall = 1'b0;
    end
    to = 0;
    while (fin_cnt == 0 && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check_eq({tag, ":finish_seen"}, 64'(fin_cnt > 0), 64'd1);
    repeat (4) @(negedge clk);
    check_eq({tag, ":finish_cnt"}, 64'(fin_cnt), 64'd1);
    check_eq({tag, ":hit"}, 64'(o_hit), 64'(e_hit));
    check_eq({tag, ":t"}, 64'(o_t), 64'(e_t));
    check_eq({tag, ":tri_index"}, 64'(o_tri_index), 64'(e_idx));
    check_eq({tag, ":busy_end"}, 64'(o_busy), 64'd0);
    check_eq({tag, ":drained"}, 64'(req_cnt - ret_cnt), 64'd0);
    if (cnt == 0) check_eq({tag, ":lat0"}, 64'(fin_cyc - start_cyc), 64'd2);
    else          check_eq({tag, ":lat"}, 64'(fin_cyc - last_res_cyc), 64'd2);
    if (any && e_hit) check_eq({tag, ":reqs_le"}, 64'(req_cnt <= groups), 64'd1);
    else              check_eq({tag, ":reqs"}, 64'(req_cnt), 64'(groups));
  endtask

  initial begin
    int to;
    reset = 1'b1; i_start = 1'b0; i_tri_cnt = '0; i_any_hit = 1'b0; i_t_max = T_SAT;
    bus.req_ready = 1'b0; bus.res_valid = 1'b0; bus.res_hit = '0; bus.res_t = '0;
    win_idx = -1; hit_seen = 1'b0; req_cnt = 0; ret_cnt = 0; fin_cnt = 0;
    exp_next_idx = 0; last_res_cyc = 0; fin_cyc = 0;
    repeat (3) @(negedge clk);
    check_eq("rst:busy", 64'(o_busy), 64'd0);
    check_eq("rst:req_valid", 64'(bus.req_valid), 64'd0);
    check_eq("rst:t", 64'(o_t), 64'(T_SAT));
    check_eq("rst:hit", 64'(o_hit), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // closest hit with a masked trailing lane
    fill(5, 0);
    th[2] = 1'b1; tt[2] = 32'h0003_0000;
    th[4] = 1'b1; tt[4] = 32'h0001_8000;
    th[5] = 1'b1; tt[5] = 32'h0000_0000;
    lat = 4; rdy_rand = 1'b0;
    run_batch("basic", 5, 1'b0, T_SAT, 0);

    fill(0, 0);
    run_batch("empty", 0, 1'b0, T_SAT, 0);

    // any-hit stops issuing once beat 1 is consumed
    fill(16, 0);
    th[3]  = 1'b1; tt[3]  = 32'h0004_0000;
    th[9]  = 1'b1; tt[9]  = 32'h0000_0100;
    th[12] = 1'b1; tt[12] = 32'h0000_0010;
    run_batch("anyhit", 16, 1'b1, T_SAT, 0);

    fill(40, 10);
    run_batch("stall", 40, 1'b0, T_SAT, 20);

    fill(4, 0);
    th[0] = 1'b1; tt[0] = 32'h0002_0000;
    th[1] = 1'b1; tt[1] = 32'hFFFF_FFFF;
    th[3] = 1'b1; tt[3] = 32'h0001_0000;
    run_batch("window", 4, 1'b0, 32'h0002_0000, 0);

    fill(8, 0);
    th[1] = 1'b1; tt[1] = 32'h0000_5000;
    th[6] = 1'b1; tt[6] = 32'h0000_5000;
    lat = 2; rdy_rand = 1'b1;
    run_batch("tie", 8, 1'b0, T_SAT, 0);

    // reset in the middle of issuing
    fill(20, 30); lat = 8; rdy_rand = 1'b0;
    req_cnt = 0; ret_cnt = 0; fin_cnt = 0; exp_next_idx = 0; hit_seen = 1'b0; win_idx = -1;
    res_stall = 1'b1;
    @(negedge clk);
    i_start = 1'b1; i_tri_cnt = 32'd20; i_any_hit = 1'b0; i_t_max = T_SAT;
    @(negedge clk);
    i_start = 1'b0;
    to = 0;
    while ((req_cnt - ret_cnt) < 3 && to < 50) begin
      @(negedge clk);
      to++;
    end
    check_eq("midrst:reached3", 64'((req_cnt - ret_cnt) >= 3), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst:busy", 64'(o_busy), 64'd0);
    check_eq("midrst:req_valid", 64'(bus.req_valid), 64'd0);
    check_eq("midrst:req_index", 64'(bus.req_index), 64'd0);
    check_eq("midrst:finish", 64'(o_finish), 64'd0);
    check_eq("midrst:hit", 64'(o_hit), 64'd0);
    check_eq("midrst:t", 64'(o_t), 64'(T_SAT));
    check_eq("midrst:tri_index", 64'(o_tri_index), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0; res_stall = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("midrst:no_finish", 64'(fin_cnt), 64'd0);
    fill(20, 30); lat = 3;
    run_batch("post_rst", 20, 1'b0, T_SAT, 0);

    for (int n = 0; n < 14; n++) begin
      int          cnt;
      bit          any;
      logic [31:0] tmax;
      cnt = $urandom_range(0, 30);
      any = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       tmax = T_SAT;
        1:       tmax = 32'h0003_0000;
        default: tmax = 32'h0000_8000;
      endcase
      lat      = $urandom_range(1, 7);
      rdy_rand = 1'($urandom_range(0, 1));
      fill(cnt, $urandom_range(0, 40));
      run_batch("rand", cnt, any, tmax, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tri_batch_scanner.md
Name: tri_batch_scanner

Overview:
- Next-generation batch controller for ray/triangle scanning.
- Issues triangle-group read requests to the triangle reader and consumes in-order results from LANES parallel intersection pipelines.
- Reduces the results to the closest hit, or stops early in any-hit (shadow-ray) mode.
- Sits between the ray dispatcher and the reader/intersection datapath; supports a per-batch t window and flow control on in-flight requests.

Parameters:
LANES, 2, triangles per request/result beat (1..8)
IDX_W, 32, triangle index/count width
T_W, 32, distance width (signed fixed-point, 16 fraction bits)
MAX_INFLIGHT, 8, max request beats issued but not yet returned (power of 2)
MIN_T, 0, signed lower bound of accepted t (inclusive)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle batch start; ignored while o_busy
i_tri_cnt  in  IDX_W  triangles in batch, sampled on i_start
i_any_hit  in  1  mode, sampled on i_start: 1 = terminate on first accepted hit
i_t_max  in  T_W  signed upper bound (exclusive), sampled on i_start
o_busy  out  1  batch in progress
o_req_valid  out  1  request valid
o_req_index  out  IDX_W  first triangle index of the group (multiple of LANES)
i_req_ready  in  1  reader accepts request
i_res_valid  in  1  result beat valid (in request order, one beat per request)
i_res_hit  in  LANES  per-lane raw hit flag
i_res_t  in  LANES*T_W  per-lane t; lane k at bits [T_W*(k+1)-1 : T_W*k]
o_finish  out  1  one-cycle pulse at batch end
o_hit  out  1  any accepted hit in batch
o_t  out  T_W  best t
o_tri_index  out  IDX_W  triangle index of o_t

Behaviour:
- Reset values: o_busy=0, o_req_valid=0, o_req_index=0, o_finish=0, o_hit=0, o_t=0x7FFFFFFF (saturating max for T_W), o_tri_index=0. Reset clears all counters, and the FSM returns to IDLE; a reset asserted mid-batch aborts the batch with no o_finish.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + i_start:
  - Latch count, mode and t_max.
  - Clear o_hit, set o_t=max, o_tri_index=0.
  - Set groups = ceil(cnt/LANES) and clear issue/return counters.
  - Go to ISSUE, or to DONE if cnt==0.
  - o_busy=1 from the next cycle.
- ISSUE:
  - o_req_valid = (outstanding < MAX_INFLIGHT). It is registered-free of ready (no combinational ready->valid path).
  - On valid&&ready: o_req_index advances by LANES and outstanding increments.
  - After the last group is accepted, go to DRAIN.
  - In any-hit mode, an accepted hit forces DRAIN immediately, and no further requests are issued.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: o_finish=1 for exactly one cycle, o_busy=0, go to IDLE. Results hold until the next i_start.
- Outstanding counter:
  - +1 on request handshake, -1 on i_res_valid; both in the same cycle leaves it unchanged.
  - i_res_valid while outstanding==0 is dropped.
- Result beat b (return counter) covers triangles b*LANES+k. Lanes with index >= cnt are masked.
- Lane k is accepted if: unmasked, i_res_hit[k]=1, t>=MIN_T, and t<t_max (signed compares).
- Closest-hit update: candidate = minimum accepted t across lanes, with ties going to the lower lane. Update when candidate < o_t (strict), so ties across beats keep the earlier (lower) index.
- Any-hit mode: the first accepted beat sets o_hit, o_t and o_tri_index; later beats do not change the outputs. Remaining in-flight beats are drained and discarded.
- Latency: the o_finish pulse occurs exactly 2 cycles after the last needed result beat is consumed (DRAIN->DONE registered). When cnt==0, o_finish occurs 2 cycles after i_start.
- Counters are IDX_W wide. The group computation must not overflow for cnt up to 2^IDX_W-1.

Test Plan:
- LANES=2, cnt=5, ready=1, result returns 4 cycles later; hits at tri2 t=0x00030000 and tri4 t=0x00018000 -> 3 requests (idx 0,2,4); lane1 of beat 2 is masked; o_hit=1, o_t=0x00018000, o_tri_index=4; single o_finish.
- cnt=0 -> no o_req_valid; o_finish pulses 2 cycles after i_start; o_hit=0; o_t=0x7FFFFFFF.
- Any-hit, cnt=16, hit at tri3 in beat 1 -> no request issued after the beat-1 result is accepted; in-flight beats drained; o_tri_index=3; o_finish after outstanding reaches 0.
- MAX_INFLIGHT=8, result path stalled for 20 cycles -> exactly 8 requests issued, o_req_valid low until the first result returns; all counts consistent at the end.
- Window: t_max=0x00020000, hits t=0x00020000 (idx0), t=-1 (idx1, MIN_T=0), t=0x00010000 (idx3) -> only idx3 accepted; tie test: equal t at idx1 and idx6 -> o_tri_index=1.
- Reset asserted while in ISSUE with 3 outstanding -> all outputs return to reset values immediately; no o_finish; a new i_start runs a clean batch.
